hazard_fwd_ct: RTL and testbench
================================

HAZARD_FWD_CT -- requirements
Module: hazard_fwd_ct

Interface
REQ-001 Parameter REG_W, default 4: register-specifier width.
REQ-002 Parameter FWD_DEPTH, default 2, legal 1..8: number of tracked in-flight result slots.
REQ-003 Parameter LOAD_LAT, default 1, legal 0..FWD_DEPTH-1: first slot index at which load data is forwardable.
REQ-004 Parameter ZERO_REG, default 0: when 1, specifier 0 never matches for forwarding or stalls.
REQ-005 FW = clog2(FWD_DEPTH+1), derived, width of forward selects.
REQ-006 clk  in  1  sole clock, all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 issue_valid  in  1  instruction present in decode this cycle.
REQ-009 issue_wr  in  1  issuing instruction writes a register.
REQ-010 issue_load  in  1  issuing instruction is a load.
REQ-011 issue_dest  in  REG_W  issuing instruction destination.
REQ-012 src1_reg  in  REG_W  operand A source.
REQ-013 src2_reg  in  REG_W  operand B source.
REQ-014 imm  in  1  operand B is an immediate; src2_reg ignored.
REQ-015 flush  in  1  discard all in-flight entries (branch redirect).
REQ-016 forward_a  out  FW  operand A select: 0 = register file, k+1 = slot k.
REQ-017 forward_b  out  FW  operand B select, same encoding.
REQ-018 stall  out  1  load-use stall; decode holds, bubble inserted.
REQ-019 stall_cnt  out  16  stall-cycle performance counter.

Function
REQ-020 Block SHALL hold FWD_DEPTH slots, each {v, dest, ld}; slot 0 = one stage ahead of decode, slot k = k+1 stages ahead.
REQ-021 Every cycle slots SHALL shift: slot k+1 <= slot k, oldest slot discarded.
REQ-022 Slot 0 SHALL load {issue_wr, issue_dest, issue_load} when accept = issue_valid & ~stall & ~flush; otherwise slot 0 SHALL load v=0.
REQ-023 Slot k matches source s when v=1, dest==s, and not (ZERO_REG=1 and s==0).
REQ-024 forward_a SHALL equal k+1 for the lowest-index matching slot k of src1_reg, else 0; combinational, zero latency.
REQ-025 forward_b SHALL follow REQ-024 for src2_reg, and SHALL be 0 when imm=1.
REQ-026 forward_a and forward_b SHALL be 0 when issue_valid=0 or flush=1.
REQ-027 stall SHALL assert when issue_valid=1, flush=0, and the lowest-index matching slot k of src1_reg, or of src2_reg when imm=0, has ld=1 and k < LOAD_LAT.
REQ-028 Older matching slots SHALL NOT cause a stall when a younger non-load slot matches; only the lowest-index match decides.
REQ-029 While stall=1, forward selects SHALL still reflect REQ-024/025; the consumer ignores them.
REQ-030 Stall SHALL clear automatically once the load shifts to slot >= LOAD_LAT; stall duration = LOAD_LAT - k cycles.
REQ-031 flush SHALL clear v in all slots at the next edge, overriding shift and accept; the issuing instruction is discarded.
REQ-032 stall_cnt SHALL increment by 1 on each edge with stall=1, saturating at 16'hFFFF.
REQ-033 LOAD_LAT=0 SHALL never assert stall.

Reset
REQ-034 rst_n=0 SHALL asynchronously clear all slot v/dest/ld and stall_cnt to 0; forward_a, forward_b, stall read 0 while reset is held.
REQ-035 Reset asserted mid-stall SHALL drop stall immediately; first cycle after release behaves as empty pipeline.

Verification
REQ-036 Defaults; issue r3 write, next cycle src1=3, src2=3, imm=0 -> forward_a=1, forward_b=1, stall=0.
REQ-037 Defaults; issue r5 write, then unrelated write r6, then src1=5 -> forward_a=2; with r5 written by both prior instructions -> forward_a=1.
REQ-038 Defaults; load r2, next cycle src2=2 -> stall=1 one cycle, stall_cnt=1, following cycle stall=0, forward_b=2.
REQ-039 FWD_DEPTH=4, LOAD_LAT=2; load r7, next src1=7 -> stall 2 cycles, then forward_a=3, stall_cnt=2.
REQ-040 Write r4 then flush; next cycle src1=4 -> forward_a=0; imm=1 with src2=4 after write r4 -> forward_b=0.
REQ-041 ZERO_REG=1; write r0 then src1=0 -> forward_a=0; load r0 then src1=0 -> stall=0.

Source files
------------

// File: rtl/hazard_fwd_ct.sv
// hazard_fwd_ct -- operand forwarding select and load-use stall control.
//
// Tracks FWD_DEPTH in-flight result slots. Slot 0 holds the instruction one
// stage ahead of decode and slot k holds the one k+1 stages ahead. Every cycle
// the slots shift one place and the oldest is dropped. Decode source
// specifiers are compared against the slots. The youngest match picks the
// forward source. If that match is a load whose data is not ready yet, the
// block requests a stall.
//
// Issue handshake: issue_valid offers the instruction in decode. The
// instruction is taken into slot 0 only on a rising edge where
// issue_valid=1, stall=0 and flush=0. While stall=1 the producer must hold
// the same instruction on the issue_* and src* inputs. A bubble (v=0) enters
// slot 0 on every edge where nothing is taken.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   issue_valid     instruction present in decode
//   issue_wr        issuing instruction writes issue_dest
//   issue_load      issuing instruction is a load
//   issue_dest      destination specifier of the issuing instruction
//   src1_reg        operand A source specifier
//   src2_reg        operand B source specifier (ignored when imm=1)
//   imm             operand B is an immediate
//   flush           invalidate every in-flight slot and drop the issue
//   forward_a/b     0 = register file, k+1 = forward from slot k
//   stall           load-use stall request
//   stall_cnt       saturating count of stalled cycles
module hazard_fwd_ct #(
  parameter int REG_W     = 4,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int ZERO_REG  = 0,
  localparam int FW       = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_wr,
  input  logic             issue_load,
  input  logic [REG_W-1:0] issue_dest,
  input  logic [REG_W-1:0] src1_reg,
  input  logic [REG_W-1:0] src2_reg,
  input  logic             imm,
  input  logic             flush,
  output logic [FW-1:0]    forward_a,
  output logic [FW-1:0]    forward_b,
  output logic             stall,
  output logic [15:0]      stall_cnt
);

  logic [FWD_DEPTH-1:0] slot_v;
  logic [FWD_DEPTH-1:0] slot_ld;
  logic [REG_W-1:0]     slot_dest [FWD_DEPTH];

  logic [FW-1:0] sel_a;
  logic [FW-1:0] sel_b;
  logic          early_ld_a;
  logic          early_ld_b;
  logic          zero_a;
  logic          zero_b;
  logic          active;
  logic          accept;

  // Register 0 is hard-wired when ZERO_REG is set, so it never matches a slot.
  assign zero_a = (ZERO_REG != 0) && (src1_reg == '0);
  assign zero_b = (ZERO_REG != 0) && (src2_reg == '0);

  // Scan from the oldest slot down to slot 0. A later hit overwrites an
  // earlier one, so the youngest match decides both the select and whether
  // the data is still in flight as a load.
  always_comb begin
    sel_a      = '0;
    sel_b      = '0;
    early_ld_a = 1'b0;
    early_ld_b = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (slot_v[k] && (slot_dest[k] == src1_reg) && !zero_a) begin
        sel_a      = FW'(k + 1);
        early_ld_a = slot_ld[k] && (k < LOAD_LAT);
      end
      if (slot_v[k] && (slot_dest[k] == src2_reg) && !zero_b) begin
        sel_b      = FW'(k + 1);
        early_ld_b = slot_ld[k] && (k < LOAD_LAT);
      end
    end
  end

  // rst_n gates the outputs so that stall drops at once when reset is applied
  // mid-stall, without waiting for the slot clear to propagate.
  assign active    = rst_n && issue_valid && !flush;
  assign forward_a = active ? sel_a : '0;
  assign forward_b = (active && !imm) ? sel_b : '0;
  assign stall     = active && (early_ld_a || (!imm && early_ld_b));
  assign accept    = issue_valid && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v  <= '0;
      slot_ld <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        slot_dest[k] <= '0;
      end
    end else if (flush) begin
      // Flush wins over both shift and accept.
      slot_v <= '0;
    end else begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        slot_v[k]    <= slot_v[k-1];
        slot_ld[k]   <= slot_ld[k-1];
        slot_dest[k] <= slot_dest[k-1];
      end
      slot_v[0]    <= accept && issue_wr;
      slot_ld[0]   <= accept && issue_load;
      slot_dest[0] <= issue_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ct.sv
// Bench for hazard_fwd_ct. Three instances share one stimulus stream:
//   inst 0: defaults (FWD_DEPTH=2, LOAD_LAT=1)
//   inst 1: FWD_DEPTH=4, LOAD_LAT=2
//   inst 2: ZERO_REG=1
// The reference model keeps, per instance, a history of what was taken from
// decode in each past cycle (index 0 = previous cycle) and derives the
// expected selects and stall from the youngest matching entry.
module tb_hazard_fwd_ct;

  typedef struct packed {
    logic       v;
    logic [3:0] d;
    logic       ld;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic       issue_wr = 1'b0;
  logic       issue_load = 1'b0;
  logic [3:0] issue_dest = '0;
  logic [3:0] src1_reg = '0;
  logic [3:0] src2_reg = '0;
  logic       imm = 1'b0;
  logic       flush = 1'b0;

  logic [1:0]  fa_0, fb_0, fa_2, fb_2;
  logic [2:0]  fa_1, fb_1;
  logic        st_0, st_1, st_2;
  logic [15:0] cnt_0, cnt_1, cnt_2;

  // Reference model state
  ent_t        hist [3][8];
  int          dep [3] = '{2, 4, 2};
  int          lat [3] = '{1, 2, 1};
  int          zr  [3] = '{0, 0, 1};
  int          mdl_cnt [3];
  int          exp_fa [3];
  int          exp_fb [3];
  int          exp_cnt [3];
  logic        exp_st [3];

  // Outputs sampled at the most recent negedge
  logic [2:0]  got_fa [3];
  logic [2:0]  got_fb [3];
  logic        got_st [3];
  logic [15:0] got_cnt [3];

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_fwd_ct u_def (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_load(issue_load), .issue_dest(issue_dest), .src1_reg(src1_reg),
    .src2_reg(src2_reg), .imm(imm), .flush(flush),
    .forward_a(fa_0), .forward_b(fb_0), .stall(st_0), .stall_cnt(cnt_0)
  );

  hazard_fwd_ct #(.FWD_DEPTH(4), .LOAD_LAT(2)) u_deep (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_load(issue_load), .issue_dest(issue_dest), .src1_reg(src1_reg),
    .src2_reg(src2_reg), .imm(imm), .flush(flush),
    .forward_a(fa_1), .forward_b(fb_1), .stall(st_1), .stall_cnt(cnt_1)
  );

  hazard_fwd_ct #(.ZERO_REG(1)) u_zero (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_load(issue_load), .issue_dest(issue_dest), .src1_reg(src1_reg),
    .src2_reg(src2_reg), .imm(imm), .flush(flush),
    .forward_a(fa_2), .forward_b(fb_2), .stall(st_2), .stall_cnt(cnt_2)
  );

  // ---------------- model ----------------
  function automatic int youngest(int i, logic [3:0] s);
    for (int k = 0; k < dep[i]; k++) begin
      if (hist[i][k].v && hist[i][k].d == s && !(zr[i] != 0 && s == 4'd0)) return k;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mdl_cnt[i] = 0;
      for (int k = 0; k < 8; k++) hist[i][k] = '0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic wr, input logic ld, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2, input logic im,
                       input logic fl);
    issue_valid = v;
    issue_wr    = wr;
    issue_load  = ld;
    issue_dest  = d;
    src1_reg    = s1;
    src2_reg    = s2;
    imm         = im;
    flush       = fl;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: sample outputs and model expectations at the negedge,
  // then advance the model with the same inputs just after the rising edge.
  task automatic step();
    int ka, kb;
    logic acc;
    @(negedge clk);
    got_fa[0] = {1'b0, fa_0}; got_fb[0] = {1'b0, fb_0}; got_st[0] = st_0; got_cnt[0] = cnt_0;
    got_fa[1] = fa_1;         got_fb[1] = fb_1;         got_st[1] = st_1; got_cnt[1] = cnt_1;
    got_fa[2] = {1'b0, fa_2}; got_fb[2] = {1'b0, fb_2}; got_st[2] = st_2; got_cnt[2] = cnt_2;
    for (int i = 0; i < 3; i++) begin
      ka = youngest(i, src1_reg);
      kb = youngest(i, src2_reg);
      exp_fa[i]  = (issue_valid && !flush && ka >= 0) ? ka + 1 : 0;
      exp_fb[i]  = (issue_valid && !flush && !imm && kb >= 0) ? kb + 1 : 0;
      exp_st[i]  = issue_valid && !flush &&
                   ((ka >= 0 && hist[i][ka].ld && ka < lat[i]) ||
                    (!imm && kb >= 0 && hist[i][kb].ld && kb < lat[i]));
      exp_cnt[i] = mdl_cnt[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      acc = issue_valid && !exp_st[i] && !flush;
      if (flush) begin
        for (int k = 0; k < 8; k++) hist[i][k].v = 1'b0;
      end else begin
        for (int k = dep[i] - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = '{v: (acc && issue_wr), d: issue_dest, ld: issue_load};
      end
      if (exp_st[i] && mdl_cnt[i] != 65535) mdl_cnt[i]++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    drive(1, 1, 1, 3, 3, 3, 0, 0);
    @(negedge clk);
    n_checks++;
    if (fa_0 !== 2'd0 || fb_0 !== 2'd0 || st_0 !== 1'b0 || cnt_0 !== 16'd0)
      $display("FAIL reset_def: fa=%0d fb=%0d st=%0b cnt=%0d want all 0", fa_0, fb_0, st_0, cnt_0);
    else n_pass++;
    n_checks++;
    if (fa_1 !== 3'd0 || fb_1 !== 3'd0 || st_1 !== 1'b0 || cnt_1 !== 16'd0)
      $display("FAIL reset_deep: fa=%0d fb=%0d st=%0b cnt=%0d want all 0", fa_1, fb_1, st_1, cnt_1);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fwd_basic();
    do_reset();
    drive(1, 1, 0, 3, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 3, 3, 0, 0); step();
    n_checks++;
    if (got_fa[0] !== 3'd1) $display("FAIL basic_fa: got %0d want 1", got_fa[0]); else n_pass++;
    n_checks++;
    if (got_fb[0] !== 3'd1) $display("FAIL basic_fb: got %0d want 1", got_fb[0]); else n_pass++;
    n_checks++;
    if (got_st[0] !== 1'b0) $display("FAIL basic_stall: got %0b want 0", got_st[0]); else n_pass++;
  endtask

  task automatic test_fwd_priority();
    do_reset();
    drive(1, 1, 0, 5, 0, 0, 0, 0); step();
    drive(1, 1, 0, 6, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 5, 0, 1, 0); step();
    n_checks++;
    if (got_fa[0] !== 3'd2) $display("FAIL prio_older: got %0d want 2", got_fa[0]); else n_pass++;
    n_checks++;
    if (got_fa[1] !== 3'd2) $display("FAIL prio_older_deep: got %0d want 2", got_fa[1]); else n_pass++;
    do_reset();
    drive(1, 1, 0, 5, 0, 0, 0, 0); step();
    drive(1, 1, 0, 5, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 5, 0, 1, 0); step();
    n_checks++;
    if (got_fa[0] !== 3'd1) $display("FAIL prio_younger: got %0d want 1", got_fa[0]); else n_pass++;
    // Younger non-load match hides an older load: no stall.
    do_reset();
    drive(1, 1, 1, 8, 0, 0, 0, 0); step();
    drive(1, 1, 0, 8, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 8, 0, 1, 0); step();
    n_checks++;
    if (got_st[1] !== 1'b0) $display("FAIL prio_hide_load: got %0b want 0", got_st[1]); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 1, 2, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 2, 0, 0); step();
    n_checks++;
    if (got_st[0] !== 1'b1) $display("FAIL lu_stall: got %0b want 1", got_st[0]); else n_pass++;
    step();
    n_checks++;
    if (got_st[0] !== 1'b0) $display("FAIL lu_release: got %0b want 0", got_st[0]); else n_pass++;
    n_checks++;
    if (got_fb[0] !== 3'd2) $display("FAIL lu_fb: got %0d want 2", got_fb[0]); else n_pass++;
    n_checks++;
    if (got_cnt[0] !== 16'd1) $display("FAIL lu_cnt: got %0d want 1", got_cnt[0]); else n_pass++;
  endtask

  task automatic test_deep_load();
    do_reset();
    drive(1, 1, 1, 7, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 7, 0, 1, 0); step();
    n_checks++;
    if (got_st[1] !== 1'b1) $display("FAIL deep_stall1: got %0b want 1", got_st[1]); else n_pass++;
    step();
    n_checks++;
    if (got_st[1] !== 1'b1) $display("FAIL deep_stall2: got %0b want 1", got_st[1]); else n_pass++;
    step();
    n_checks++;
    if (got_st[1] !== 1'b0) $display("FAIL deep_release: got %0b want 0", got_st[1]); else n_pass++;
    n_checks++;
    if (got_fa[1] !== 3'd3) $display("FAIL deep_fa: got %0d want 3", got_fa[1]); else n_pass++;
    n_checks++;
    if (got_cnt[1] !== 16'd2) $display("FAIL deep_cnt: got %0d want 2", got_cnt[1]); else n_pass++;
  endtask

  task automatic test_flush_imm();
    do_reset();
    drive(1, 1, 0, 4, 0, 0, 0, 0); step();
    drive(1, 1, 0, 4, 4, 0, 1, 1); step();
    n_checks++;
    if (got_fa[0] !== 3'd0) $display("FAIL flush_cycle_fa: got %0d want 0", got_fa[0]); else n_pass++;
    drive(1, 0, 0, 0, 4, 0, 1, 0); step();
    n_checks++;
    if (got_fa[0] !== 3'd0) $display("FAIL flush_after_fa: got %0d want 0", got_fa[0]); else n_pass++;
    do_reset();
    drive(1, 1, 0, 4, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 4, 1, 0); step();
    n_checks++;
    if (got_fb[0] !== 3'd0) $display("FAIL imm_fb: got %0d want 0", got_fb[0]); else n_pass++;
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 1, 0); step();
    n_checks++;
    if (got_fa[2] !== 3'd0) $display("FAIL zero_fa: got %0d want 0", got_fa[2]); else n_pass++;
    n_checks++;
    if (got_fa[0] !== 3'd1) $display("FAIL nonzero_fa: got %0d want 1", got_fa[0]); else n_pass++;
    do_reset();
    drive(1, 1, 1, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 1, 0); step();
    n_checks++;
    if (got_st[2] !== 1'b0) $display("FAIL zero_stall: got %0b want 0", got_st[2]); else n_pass++;
    n_checks++;
    if (got_st[0] !== 1'b1) $display("FAIL nonzero_stall: got %0b want 1", got_st[0]); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 1, 1, 2, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 2, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if (st_0 !== 1'b1) $display("FAIL midrst_pre: got %0b want 1", st_0); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (st_0 !== 1'b0 || st_1 !== 1'b0) $display("FAIL midrst_drop: got %0b/%0b want 0/0", st_0, st_1);
    else n_pass++;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    n_checks++;
    if (got_st[0] !== 1'b0 || got_fa[0] !== 3'd0 || got_cnt[0] !== 16'd0)
      $display("FAIL midrst_after: st=%0b fa=%0d cnt=%0d want 0/0/0", got_st[0], got_fa[0], got_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
      step();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_fa[i] !== 3'(exp_fa[i]) || got_fb[i] !== 3'(exp_fb[i]) ||
            got_st[i] !== exp_st[i] || got_cnt[i] !== 16'(exp_cnt[i]))
          $display("FAIL rand inst%0d cyc%0d: fa=%0d fb=%0d st=%0b cnt=%0d want %0d %0d %0b %0d",
                   i, n, got_fa[i], got_fb[i], got_st[i], got_cnt[i],
                   exp_fa[i], exp_fb[i], exp_st[i], exp_cnt[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_basic();
    test_fwd_priority();
    test_load_use();
    test_deep_load();
    test_flush_imm();
    test_zero_reg();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
